// File: rtl/tb_counter_wrap.sv
// Purpose: 10-bit up/down wrapping counter with a built-in reference checker and sticky err flag.
// Latency: count follows mode one clock after it is sampled; err rises one clock after a bad transition.
// Backpressure: none; counts every cycle, with no hold state. Optional macro TB_COUNTER_ASSERT_EN adds assertions/covers.
module tb_counter_wrap #(
    parameter int               WIDTH   = 10,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Counter core state
    logic [WIDTH-1:0] cnt_q, cnt_d;
    // Checker state: previous-cycle snapshot of the counter and its controls
    logic             err_q, err_d;
    logic             past_valid_q, past_valid_d;
    logic [WIDTH-1:0] prev_cnt_q, prev_cnt_d;
    logic             prev_mode_q, prev_mode_d;
    logic             prev_rst_q, prev_rst_d;

    // Check results for the transition that produced the current cnt_q
    logic [WIDTH-1:0] exp_up, exp_dn;
    logic             c1_fail, c2_fail, c3_fail;

    // Counter next state: reset wins, otherwise step by one modulo 2**WIDTH
    always_comb begin
        cnt_d = cnt_q;
        if (rst) begin
            cnt_d = RST_VAL;
        end else if (mode) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Reference model: compare the current count against the last cycle's snapshot
    always_comb begin
        exp_up  = prev_cnt_q + ONE;
        exp_dn  = prev_cnt_q - ONE;
        // C1 is not gated by past_valid: past_valid is still 0 on the cycle after reset.
        c1_fail = prev_rst_q && (cnt_q != RST_VAL);
        c2_fail = past_valid_q && !prev_rst_q && !prev_mode_q && (cnt_q != exp_up);
        c3_fail = past_valid_q && !prev_rst_q &&  prev_mode_q && (cnt_q != exp_dn);
    end

    // Checker next state: snapshot this cycle, make err sticky until reset
    always_comb begin
        err_d        = err_q | c1_fail | c2_fail | c3_fail;
        past_valid_d = 1'b1;
        prev_cnt_d   = cnt_q;
        prev_mode_d  = mode;
        // Recording rst itself is what arms C1 for the cycle after reset.
        prev_rst_d   = rst;
        if (rst) begin
            err_d        = 1'b0;
            past_valid_d = 1'b0;
            prev_cnt_d   = '0;
            prev_mode_d  = 1'b0;
        end
    end

    // State registers; reset is handled synchronously in the next-state logic
    always_ff @(posedge clk) begin
        cnt_q        <= cnt_d;
        err_q        <= err_d;
        past_valid_q <= past_valid_d;
        prev_cnt_q   <= prev_cnt_d;
        prev_mode_q  <= prev_mode_d;
        prev_rst_q   <= prev_rst_d;
    end

    assign count = cnt_q;
    assign err   = err_q;

`ifdef TB_COUNTER_ASSERT_EN
    logic up_wrap, dn_wrap;

    // Wrap events, used only by the covers below
    always_comb begin
        up_wrap = past_valid_q && !prev_rst_q && !prev_mode_q
                  && (prev_cnt_q == {WIDTH{1'b1}}) && (cnt_q == '0);
        dn_wrap = past_valid_q && !prev_rst_q &&  prev_mode_q
                  && (prev_cnt_q == '0) && (cnt_q == {WIDTH{1'b1}});
    end

    // Report each failing check by name with its values
    always @(posedge clk) begin
        assert (!c1_fail)
            else $error("C1 reset: count=%0d expected=%0d", cnt_q, RST_VAL);
        assert (!c2_fail)
            else $error("C2 up: prev=%0d count=%0d expected=%0d", prev_cnt_q, cnt_q, exp_up);
        assert (!c3_fail)
            else $error("C3 down: prev=%0d count=%0d expected=%0d", prev_cnt_q, cnt_q, exp_dn);
    end

    cover property (@(posedge clk) up_wrap);
    cover property (@(posedge clk) dn_wrap);
`endif

endmodule

// File: tb/tb_tb_counter_wrap.sv
// Bench for tb_counter_wrap: scoreboard of expected count/err per clock.
// Each step drives rst/mode, pushes the model's prediction, then pops and compares after the edge.
// Corruption of the count is injected with force across one edge.
module tb_tb_counter_wrap;

    localparam int W = 10;

    logic         clk;
    logic         rst;
    logic         mode;
    logic [W-1:0] count;
    logic         err;

    tb_counter_wrap #(.WIDTH(W), .RST_VAL('0)) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .count (count),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] cnt;
        logic         err;
        bit           chk_cnt;
    } exp_t;

    exp_t         sb_q[$];
    int           n_chk  = 0;
    int           n_pass = 0;

    // Reference model state
    logic [W-1:0] m_cnt  = '0;
    logic         m_err  = 1'b0;
    bit           m_cnt_known = 1'b1;
    bit           m_corrupt   = 1'b0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict, wait for the edge, compare
    task automatic step(input logic r, input logic m, input string tag);
        exp_t e;
        exp_t got;
        rst  = r;
        mode = m;
        if (r) begin
            m_cnt       = '0;
            m_err       = 1'b0;
            m_cnt_known = 1'b1;
            m_corrupt   = 1'b0;
        end else begin
            m_cnt = m ? m_cnt - 10'd1 : m_cnt + 10'd1;
            if (m_corrupt) m_err = 1'b1;
        end
        e.tag     = tag;
        e.cnt     = m_cnt;
        e.err     = m_err;
        e.chk_cnt = m_cnt_known;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            got = sb_q.pop_front();
            if (got.chk_cnt) check({got.tag, "_count"}, count, got.cnt);
            check({got.tag, "_err"}, err, got.err);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b0;
        mode = 1'b0;
        @(posedge clk);
        #1;

        // Reset with mode=1: reset wins
        step(1'b1, 1'b1, "reset");

        // 20 up steps from 0
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "up20");
        check("up20_final", count, 20);

        // One down, then three up: 19 then 22
        step(1'b0, 1'b1, "dn1");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "up3");
        check("up3_final", count, 22);

        // Mode toggling every cycle
        for (int i = 0; i < 8; i++) step(1'b0, logic'(i % 2), "toggle");

        // Reset pulse mid-count at 300 with mode=0
        step(1'b1, 1'b0, "rst_pre300");
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, "to300");
        check("at300", count, 300);
        step(1'b1, 1'b0, "rst_mid");
        step(1'b0, 1'b0, "after_rst_mid");

        // Run to 1023, wrap up to 0, then wrap down to 1023
        step(1'b1, 1'b0, "rst_prewrap");
        for (int i = 0; i < 1023; i++) step(1'b0, 1'b0, "to1023");
        check("at1023", count, 1023);
        step(1'b0, 1'b0, "up_wrap");
        step(1'b0, 1'b1, "dn_wrap");
        step(1'b0, 1'b1, "dn_after_wrap");

        // Corrupt the count 5 -> 9 and expect a sticky err
        step(1'b1, 1'b0, "rst_precorrupt");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "to5");
        force dut.cnt_q = 10'd9;
        m_corrupt   = 1'b1;
        m_cnt_known = 1'b0;
        step(1'b0, 1'b0, "corrupt");
        release dut.cnt_q;
        for (int i = 0; i < 4; i++) step(1'b0, logic'(i % 2), "err_sticky");
        step(1'b1, 1'b0, "err_clear");
        step(1'b0, 1'b0, "post_clear");
        step(1'b0, 1'b1, "post_clear_dn");

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
